// File: rtl/traffic_phase_arbiter_if.sv
// Request/lamp bundle between the phase arbiter and its environment.
// master drives the sensors and requests; slave (the arbiter) drives the lamps.
interface traffic_phase_arbiter_if;
    logic       tick;
    logic       ms;
    logic       ss;
    logic       ped_req;
    logic       emg_req;
    logic [1:0] ml;
    logic [1:0] sl;
    logic       walk;

    modport master (
        output tick,
        output ms,
        output ss,
        output ped_req,
        output emg_req,
        input  ml,
        input  sl,
        input  walk
    );

    modport slave (
        input  tick,
        input  ms,
        input  ss,
        input  ped_req,
        input  emg_req,
        output ml,
        output sl,
        output walk
    );
endinterface

// File: rtl/traffic_phase_arbiter.sv
// Intersection phase scheduler: shares right-of-way between the side street, a latched
// pedestrian call and an emergency preempt, with tick-counted dwells and Moore lamps.
module traffic_phase_arbiter #(
    parameter int unsigned MIN_GREEN = 180,
    parameter int unsigned YEL       = 10,
    parameter int unsigned SIDE_MAX  = 120,
    parameter int unsigned WALK      = 20,
    parameter int unsigned TW        = 8
) (
    input logic                   clk,
    input logic                   rst_n,
    traffic_phase_arbiter_if.slave bus
);

    typedef enum logic [2:0] {
        StMg,
        StMy,
        StSg,
        StSy,
        StPed
    } state_e;

    localparam logic [1:0] LampG = 2'b00;
    localparam logic [1:0] LampY = 2'b01;
    localparam logic [1:0] LampR = 2'b10;

    localparam logic [TW-1:0] TimerMax  = '1;
    localparam logic [TW-1:0] MinGreenT = TW'(MIN_GREEN);
    localparam logic [TW-1:0] YelT      = TW'(YEL);
    localparam logic [TW-1:0] SideMaxT  = TW'(SIDE_MAX);
    localparam logic [TW-1:0] WalkT     = TW'(WALK);

    state_e          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            ped_pend_q, ped_pend_d;
    logic            target_ped_q, target_ped_d;  // 1: PED, 0: SG
    logic            last_ped_q, last_ped_d;      // 1: last tie went to PED
    logic [1:0]      ml_q, ml_d;
    logic [1:0]      sl_q, sl_d;
    logic            walk_q, walk_d;
    logic            side_call;

    assign side_call = bus.ss & ~bus.ms;

    always_comb begin
        state_d      = state_q;
        target_ped_d = target_ped_q;
        last_ped_d   = last_ped_q;
        ped_pend_d   = ped_pend_q;
        timer_d      = timer_q;
        ml_d         = ml_q;
        sl_d         = sl_q;
        walk_d       = walk_q;

        case (state_q)
            StMg: begin
                if ((timer_q >= MinGreenT) && (side_call || ped_pend_q) && !bus.emg_req) begin
                    state_d = StMy;
                    if (side_call && ped_pend_q) begin
                        target_ped_d = ~last_ped_q;
                        last_ped_d   = ~last_ped_q;
                    end else begin
                        target_ped_d = ped_pend_q;
                    end
                end
            end
            StMy: begin
                if (timer_q >= YelT) begin
                    if (bus.emg_req) begin
                        state_d = StMg;
                    end else if (target_ped_q) begin
                        state_d = StPed;
                    end else begin
                        state_d = StSg;
                    end
                end
            end
            StSg: begin
                if (!bus.ss || (timer_q >= SideMaxT) || bus.emg_req) begin
                    state_d = StSy;
                end
            end
            StSy: begin
                if (timer_q >= YelT) begin
                    state_d = StMg;
                end
            end
            StPed: begin
                if (timer_q >= WalkT) begin
                    state_d = StMg;
                end
            end
            default: state_d = StMg;
        endcase

        // A press on the walk-start edge is considered served by that walk.
        if (state_q != StPed && bus.ped_req) begin
            ped_pend_d = 1'b1;
        end
        if (state_q == StMy && state_d == StPed) begin
            ped_pend_d = 1'b0;
        end

        if (state_d != state_q) begin
            timer_d = '0;
        end else if (bus.tick && timer_q != TimerMax) begin
            timer_d = timer_q + TW'(1);
        end

        unique case (state_d)
            StMg:    begin ml_d = LampG; sl_d = LampR; walk_d = 1'b0; end
            StMy:    begin ml_d = LampY; sl_d = LampR; walk_d = 1'b0; end
            StSg:    begin ml_d = LampR; sl_d = LampG; walk_d = 1'b0; end
            StSy:    begin ml_d = LampR; sl_d = LampY; walk_d = 1'b0; end
            StPed:   begin ml_d = LampR; sl_d = LampR; walk_d = 1'b1; end
            default: begin ml_d = LampR; sl_d = LampR; walk_d = 1'b0; end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StMg;
            timer_q      <= '0;
            ped_pend_q   <= 1'b0;
            target_ped_q <= 1'b0;
            last_ped_q   <= 1'b1;
            ml_q         <= LampG;
            sl_q         <= LampR;
            walk_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            ped_pend_q   <= ped_pend_d;
            target_ped_q <= target_ped_d;
            last_ped_q   <= last_ped_d;
            ml_q         <= ml_d;
            sl_q         <= sl_d;
            walk_q       <= walk_d;
        end
    end

    assign bus.ml   = ml_q;
    assign bus.sl   = sl_q;
    assign bus.walk = walk_q;

endmodule
